// File: rtl/cpc_loader_pkg.sv
// Shared definitions for the CPC ROM loader.
//   state_t        loader FSM states
//   DEF_BAD_PAGE   page used when the file extension is not a valid hex pair
//   DEF_MF2_PAGE   Multiface 2 page; also the page after a combo image's first 16K
//   DEF_N_SYS_BLK  number of 16K system-ROM blocks accepted for dl_index==0
//   sys_page()     system-ROM block (mod 4) -> 9-bit page
//   hex_nib()      ASCII '0'-'9'/'A'-'F' -> {valid, nibble}
package cpc_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_SLOT,
        ST_WRITE,
        ST_WRITE2
    } state_t;

    localparam logic [8:0]  DEF_BAD_PAGE  = 9'h1EE;
    localparam logic [8:0]  DEF_MF2_PAGE  = 9'h1FF;
    localparam int unsigned DEF_N_SYS_BLK = 8;

    function automatic logic [8:0] sys_page(input logic [1:0] blk_lo,
                                            input logic [8:0] mf2_page);
        case (blk_lo)
            2'd0:    sys_page = 9'h000;
            2'd1:    sys_page = 9'h100;
            2'd2:    sys_page = 9'h107;
            default: sys_page = mf2_page;
        endcase
    endfunction

    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        hex_nib = '0;
        if (c >= 8'h30 && c <= 8'h39)
            hex_nib = {1'b1, 4'(c - 8'h30)};
        else if (c >= 8'h41 && c <= 8'h46)
            hex_nib = {1'b1, 4'(c - 8'h37)};
    endfunction

endpackage

// File: rtl/cpc_ext_page_decode.sv
// Combinational decode of the download file extension into a ROM page.
//   dl_ext  in  16  last two extension characters, ASCII
//   page    out 9   starting page for the image
//   combo   out 1   image is a combo (first 16K page 0, then the MF2 page)
// "ZZ" selects page 0, "Z0" selects page 0 as a combo image; otherwise each
// valid hex character overrides its nibble of BAD_PAGE.
module cpc_ext_page_decode
    import cpc_loader_pkg::*;
#(
    parameter logic [8:0] BAD_PAGE = DEF_BAD_PAGE
) (
    input  logic [15:0] dl_ext,
    output logic [8:0]  page,
    output logic        combo
);

    logic [4:0] nib_hi;
    logic [4:0] nib_lo;

    always_comb begin
        nib_hi = hex_nib(dl_ext[15:8]);
        nib_lo = hex_nib(dl_ext[7:0]);
        page   = BAD_PAGE;
        combo  = 1'b0;
        if (dl_ext == 16'h5A5A) begin
            page = '0;
        end else if (dl_ext == 16'h5A30) begin
            page  = '0;
            combo = 1'b1;
        end else begin
            if (nib_hi[4]) page[7:4] = nib_hi[3:0];
            if (nib_lo[4]) page[3:0] = nib_lo[3:0];
        end
    end

endmodule

// File: rtl/cpc_rom_loader.sv
// Sequences ROM/expansion downloads from the HPS ioctl stream into SDRAM
// while the system is held in reset.
//   clk_sys, reset        clock, synchronous active-high reset
//   ce_ref                SDRAM slot strobe (1 in 16 clocks)
//   dl_active/wr/addr/data/index/ext   ioctl download stream
//   dl_wait               host stall
//   mem_wr/addr/bank/din  SDRAM write request
//   map_page -> map_hit   query of populated expansion ROM pages
//   csum                  running byte checksum
// Build option: define ROM_LOADER_CSUM_EN to enable csum; otherwise csum is 0.
module cpc_rom_loader
    import cpc_loader_pkg::*;
#(
    parameter logic [8:0]  BAD_PAGE  = DEF_BAD_PAGE,
    parameter logic [8:0]  MF2_PAGE  = DEF_MF2_PAGE,
    parameter int unsigned N_SYS_BLK = DEF_N_SYS_BLK
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_ref,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [24:0] dl_addr,
    input  logic [7:0]  dl_data,
    input  logic [7:0]  dl_index,
    input  logic [15:0] dl_ext,
    output logic        dl_wait,
    output logic        mem_wr,
    output logic [22:0] mem_addr,
    output logic [1:0]  mem_bank,
    output logic [7:0]  mem_din,
    input  logic [7:0]  map_page,
    output logic        map_hit,
    output logic [15:0] csum
);

    state_t       state, state_nxt;
    logic         active_q;
    logic         dl_rise;
    logic [8:0]   page;
    logic         combo;
    logic [8:0]   dec_page;
    logic         dec_combo;
    logic [24:0]  lat_addr;
    logic [7:0]   lat_data;
    logic [7:0]   lat_index;
    logic         drop_q;
    logic [255:0] rom_map;

    logic         take, load, start_wr, to_bank1, finish;
    logic         is_drop, dual;
    logic [22:0]  load_addr;
    logic [1:0]   load_bank;

    cpc_ext_page_decode #(.BAD_PAGE(BAD_PAGE)) u_ext_decode (
        .dl_ext (dl_ext),
        .page   (dec_page),
        .combo  (dec_combo)
    );

    assign dl_rise = dl_active & ~active_q;
    assign map_hit = rom_map[map_page];

    // System blocks past N_SYS_BLK are dropped; decided while dl_addr is
    // still valid so dl_wait never rises for them.
    assign is_drop = (dl_index == '0) && ({21'd0, dl_addr[24:14]} >= N_SYS_BLK);
    assign dual    = (lat_index[7:6] == 2'b01) || (lat_index[5:0] != '0);

    always_comb begin
        load_addr = '0;
        load_bank = '0;
        if (lat_index != '0) begin
            load_addr = {page[8], page[7:0] + lat_addr[21:14], lat_addr[13:0]};
            load_bank = {1'b0, &lat_index[7:6]};
        end else begin
            load_addr = {sys_page(lat_addr[15:14], MF2_PAGE), lat_addr[13:0]};
            load_bank = {1'b0, |lat_addr[24:16]};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        load      = 1'b0;
        start_wr  = 1'b0;
        to_bank1  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dl_wr && dl_active) begin
                    take      = 1'b1;
                    state_nxt = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (drop_q) begin
                    state_nxt = ST_IDLE;
                end else begin
                    load      = 1'b1;
                    state_nxt = ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (ce_ref) begin
                    start_wr  = 1'b1;
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (ce_ref) begin
                    if (dual && mem_bank == 2'b00) begin
                        to_bank1  = 1'b1;
                        state_nxt = ST_WRITE2;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WRITE2: begin
                if (ce_ref) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            active_q  <= 1'b0;
            page      <= '0;
            combo     <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_index <= '0;
            drop_q    <= 1'b0;
            dl_wait   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_bank  <= '0;
            mem_din   <= '0;
            rom_map   <= '0;
        end else begin
            active_q <= dl_active;
            if (take) begin
                lat_addr  <= dl_addr;
                lat_data  <= dl_data;
                lat_index <= dl_index;
                drop_q    <= is_drop;
                dl_wait   <= ~is_drop;
            end
            if (load) begin
                mem_addr <= load_addr;
                mem_bank <= load_bank;
                mem_din  <= lat_data;
            end
            if (start_wr) mem_wr <= 1'b1;
            if (to_bank1) mem_bank <= 2'b01;
            if (finish) begin
                mem_wr  <= 1'b0;
                dl_wait <= 1'b0;
                if (mem_addr[22]) rom_map[mem_addr[21:14]] <= 1'b1;
                if (combo && mem_addr[13:0] == 14'h3FFF) begin
                    page  <= MF2_PAGE;
                    combo <= 1'b0;
                end
            end
            // A new download start wins over a combo hand-over on the same clock.
            if (dl_rise && dl_index != '0) begin
                page  <= dec_page;
                combo <= dec_combo;
            end
        end
    end

`ifdef ROM_LOADER_CSUM_EN
    logic [15:0] csum_q;

    always_ff @(posedge clk_sys) begin
        if (reset)
            csum_q <= '0;
        else if (dl_rise)
            csum_q <= (take && !is_drop) ? {8'h00, dl_data} : '0;
        else if (take && !is_drop)
            csum_q <= csum_q + {8'h00, dl_data};
    end

    assign csum = csum_q;
`else
    assign csum = '0;
`endif

endmodule

// File: tb/tb_cpc_rom_loader.sv
`timescale 1ns/1ps
module tb_cpc_rom_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_ref;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic [7:0]  dl_index = '0;
    logic [15:0] dl_ext = 16'h3030;
    logic        dl_wait;
    logic        mem_wr;
    logic [22:0] mem_addr;
    logic [1:0]  mem_bank;
    logic [7:0]  mem_din;
    logic [7:0]  map_page = '0;
    logic        map_hit;
    logic [15:0] csum;
    logic [3:0]  ce_cnt = '0;

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) ce_cnt <= ce_cnt + 4'd1;
    assign ce_ref = (ce_cnt == 4'd15);

    cpc_rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr),
        .dl_data(dl_data), .dl_index(dl_index), .dl_ext(dl_ext),
        .dl_wait(dl_wait), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_bank(mem_bank), .mem_din(mem_din), .map_page(map_page),
        .map_hit(map_hit), .csum(csum)
    );

    int tests = 0;
    int failed = 0;

    // Reference model state
    int m_page = 0;
    int m_combo = 0;
    int m_csum = 0;
    bit m_map [256];
    int sys_tab [4] = '{0, 'h100, 'h107, 'h1FF};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int char_nib(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 48 && v <= 57) return v - 48;
        if (v >= 65 && v <= 70) return v - 55;
        return -1;
    endfunction

    function automatic int model_page_of(input logic [15:0] ext);
        int hi, lo, p;
        if (ext == "ZZ" || ext == "Z0") return 0;
        hi = char_nib(ext[15:8]);
        lo = char_nib(ext[7:0]);
        p = 'h1EE;
        if (hi >= 0) p = (p % 16) + 256 + hi * 16;
        if (lo >= 0) p = (p / 16) * 16 + lo;
        return p;
    endfunction

    task automatic model_start(input logic [7:0] idx, input logic [15:0] ext);
        m_csum = 0;
        if (idx != 0) begin
            m_page  = model_page_of(ext);
            m_combo = (ext == "Z0") ? 1 : 0;
        end
    endtask

    task automatic begin_dl(input logic [7:0] idx, input logic [15:0] ext);
        @(negedge clk_sys);
        dl_active = 1'b0;
        @(negedge clk_sys);
        dl_index  = idx;
        dl_ext    = ext;
        dl_active = 1'b1;
        model_start(idx, ext);
    endtask

    // Issues one byte, watches the bus for a fixed window and checks the
    // observed writes against the model.
    task automatic do_byte(input string name, input logic [24:0] a, input logic [7:0] d,
                           input bit coincident, input int drop_at,
                           output int o_n, output logic [22:0] o_addr, output logic [1:0] o_bank);
        int ai, n_exp, ea, eb, pg, blk, nseg, lat, lim;
        logic [22:0] sa [4];
        logic [1:0]  sb [4];
        logic [7:0]  sd [4];
        int          sl [4];
        logic        pw, wait1, any_wait;
        logic [1:0]  pb;
        @(negedge clk_sys);
        if (coincident) begin
            dl_active = 1'b1;
            model_start(dl_index, dl_ext);
        end
        dl_addr = a;
        dl_data = d;
        dl_wr   = 1'b1;
        ai = int'(a);
        n_exp = 0; ea = 0; eb = 0;
        if (dl_active) begin
            if (dl_index == 0) begin
                blk = ai / 16384;
                if (blk < 8) begin
                    n_exp = 1;
                    pg = sys_tab[blk % 4];
                    ea = pg * 16384 + ai % 16384;
                    eb = (blk >= 4) ? 1 : 0;
                end
            end else begin
                pg = (m_page / 256) * 256 + ((m_page % 256) + (ai / 16384) % 256) % 256;
                ea = pg * 16384 + ai % 16384;
                eb = (dl_index >= 8'hC0) ? 1 : 0;
                n_exp = (eb == 0 && (dl_index / 64 == 1 || dl_index % 64 != 0)) ? 2 : 1;
            end
        end
        @(negedge clk_sys);
        dl_wr = 1'b0;
        nseg = 0; pw = 1'b0; pb = '0; lat = -1; wait1 = dl_wait; any_wait = 1'b0;
        for (int k = 1; k <= 56; k++) begin
            if (k > 1) @(negedge clk_sys);
            if (k == drop_at) dl_active = 1'b0;
            if (mem_wr) begin
                if (!pw || mem_bank != pb) begin
                    if (nseg < 4) begin
                        sa[nseg] = mem_addr; sb[nseg] = mem_bank; sd[nseg] = mem_din; sl[nseg] = 1;
                    end
                    nseg++;
                end else if (nseg >= 1 && nseg <= 4) begin
                    sl[nseg-1]++;
                end
            end
            pw = mem_wr; pb = mem_bank;
            if (dl_wait) any_wait = 1'b1;
            if (lat < 0 && !dl_wait) lat = k;
        end
        check({name, ".nwr"}, nseg, n_exp);
        if (n_exp > 0 && nseg >= 1) begin
            check({name, ".wait_rise"}, wait1, 1);
            check({name, ".addr"}, sa[0], ea);
            check({name, ".bank"}, sb[0], eb);
            check({name, ".din"}, sd[0], d);
            check({name, ".len"}, sl[0], 16);
            lim = (n_exp == 2) ? 51 : 35;
            check({name, ".latency_ok"}, (lat > 0 && lat <= lim) ? 1 : 0, 1);
            if (n_exp == 2 && nseg >= 2) begin
                check({name, ".addr2"}, sa[1], ea);
                check({name, ".bank2"}, sb[1], 1);
                check({name, ".len2"}, sl[1], 16);
            end
        end else if (n_exp == 0) begin
            check({name, ".no_wait"}, any_wait, 0);
        end
        if (n_exp > 0) begin
            m_csum = (m_csum + int'(d)) % 65536;
            if (ea >= 'h400000) m_map[(ea / 16384) % 256] = 1'b1;
            if (m_combo != 0 && ai % 16384 == 16383) begin
                m_page  = 'h1FF;
                m_combo = 0;
            end
        end
`ifdef ROM_LOADER_CSUM_EN
        check({name, ".csum"}, csum, m_csum);
`else
        check({name, ".csum"}, csum, 0);
`endif
        o_n    = nseg;
        o_addr = (nseg > 0) ? sa[0] : '0;
        o_bank = (nseg > 0) ? sb[0] : '0;
    endtask

    task automatic map_sweep(input string name);
        int bad;
        bad = 0;
        for (int p = 0; p < 256; p++) begin
            map_page = p[7:0];
            #1;
            if (map_hit !== m_map[p]) bad++;
        end
        check(name, bad, 0);
    endtask

    task automatic map_probe(input string name, input logic [7:0] pg, input logic exp);
        map_page = pg;
        #1;
        check(name, map_hit, exp);
    endtask

    typedef struct {
        bit          start;
        logic [7:0]  idx;
        logic [15:0] ext;
        logic [24:0] addr;
        logic [7:0]  data;
        int          nwr;
        logic [22:0] eaddr;
        logic [1:0]  ebank;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [22:0] oa;
        logic [1:0]  ob;
        logic [15:0] exts [8];
        logic [7:0]  idxs [6];
        logic [24:0] ra;
        bit seen;

        foreach (m_map[i]) m_map[i] = 1'b0;

        tbl[0] = '{1'b1, 8'h00, "00", 25'h0004005, 8'h11, 1, 23'h400005, 2'd0};
        tbl[1] = '{1'b0, 8'h00, "00", 25'h001C000, 8'h22, 1, 23'h7FC000, 2'd1};
        tbl[2] = '{1'b0, 8'h00, "00", 25'h0020000, 8'h33, 0, 23'h000000, 2'd0};
        tbl[3] = '{1'b1, 8'h41, "07", 25'h0000010, 8'h44, 2, 23'h41C010, 2'd0};
        tbl[4] = '{1'b1, 8'h80, "Z0", 25'h0003FFF, 8'h55, 1, 23'h003FFF, 2'd0};
        tbl[5] = '{1'b0, 8'h80, "Z0", 25'h0004000, 8'h66, 1, 23'h400000, 2'd0};
        tbl[6] = '{1'b1, 8'h80, "Q!", 25'h0000123, 8'h77, 1, 23'h7B8123, 2'd0};

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst.dl_wait", dl_wait, 0);
        check("rst.mem_wr", mem_wr, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_bank", mem_bank, 0);
        check("rst.mem_din", mem_din, 0);
        check("rst.csum", csum, 0);
        map_sweep("rst.map_clear");
        @(negedge clk_sys);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            if (tbl[i].start) begin_dl(tbl[i].idx, tbl[i].ext);
            do_byte($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].data, 1'b0, 0, n, oa, ob);
            check($sformatf("tbl%0d.vec_nwr", i), n, tbl[i].nwr);
            if (tbl[i].nwr > 0) begin
                check($sformatf("tbl%0d.vec_addr", i), oa, tbl[i].eaddr);
                check($sformatf("tbl%0d.vec_bank", i), ob, tbl[i].ebank);
            end
        end
        map_probe("map.page07", 8'h07, 1'b1);
        map_probe("map.pageEE", 8'hEE, 1'b1);
        map_probe("map.page08", 8'h08, 1'b0);
        map_sweep("map.after_tbl");

        // Checksum of two bytes wraps through the low byte
        begin_dl(8'h80, "10");
        do_byte("csum.b0", 25'h0000000, 8'hFF, 1'b0, 0, n, oa, ob);
        do_byte("csum.b1", 25'h0000001, 8'h02, 1'b0, 0, n, oa, ob);
`ifdef ROM_LOADER_CSUM_EN
        check("csum.value", csum, 16'h0101);
`else
        check("csum.value", csum, 16'h0000);
`endif

        // dl_active falls mid-write: write completes, later bytes ignored
        begin_dl(8'h80, "2B");
        do_byte("fall.inflight", 25'h0000123, 8'hA5, 1'b0, 5, n, oa, ob);
        check("fall.inflight_n", n, 1);
        do_byte("fall.ignored", 25'h0000200, 8'h5A, 1'b0, 0, n, oa, ob);
        check("fall.ignored_n", n, 0);

        // Rising dl_active on the same clock as dl_wr uses the new page
        @(negedge clk_sys);
        dl_active = 1'b0;
        dl_index  = 8'h80;
        dl_ext    = "3A";
        @(negedge clk_sys);
        do_byte("coinc", 25'h0000000, 8'h99, 1'b1, 0, n, oa, ob);
        check("coinc.addr_const", oa, 23'h4E8000);

        // Randomized downloads
        exts = '{"00", "07", "3A", "ZZ", "Z0", "Q!", "F9", "xA"};
        idxs = '{8'h00, 8'h01, 8'h41, 8'h80, 8'hC0, 8'h3F};
        for (int t = 0; t < 8; t++) begin
            begin_dl(idxs[$urandom_range(0, 5)], exts[$urandom_range(0, 7)]);
            for (int b = 0; b < 4; b++) begin
                if (dl_index == 0) begin
                    ra = 25'($urandom_range(0, 'h27FFF));
                end else begin
                    ra = 25'($urandom);
                    if ($urandom_range(0, 3) == 0) ra[13:0] = 14'h3FFF;
                end
                do_byte($sformatf("rnd%0d_%0d", t, b), ra, 8'($urandom), 1'b0, 0, n, oa, ob);
            end
        end
        map_sweep("map.after_rnd");

        // Reset while a write is in flight
        begin_dl(8'h80, "12");
        @(negedge clk_sys);
        dl_addr = '0;
        dl_data = 8'h5A;
        dl_wr   = 1'b1;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk_sys);
            if (mem_wr) seen = 1'b1;
        end
        check("rstw.wr_seen", seen, 1);
        reset     = 1'b1;
        dl_active = 1'b0;
        @(negedge clk_sys);
        check("rstw.mem_wr", mem_wr, 0);
        check("rstw.dl_wait", dl_wait, 0);
        check("rstw.mem_addr", mem_addr, 0);
        check("rstw.csum", csum, 0);
        foreach (m_map[i]) m_map[i] = 1'b0;
        m_page = 0; m_combo = 0; m_csum = 0;
        reset = 1'b0;
        map_sweep("rstw.map_clear");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
